// File: rtl/sobel_mem_scheduler.sv
// Memory port scheduler for the Sobel pipeline.
// Arbitrates round-robin between window-fetch reads and gradient writebacks,
// latches the granted request, drives the port block, waits out busy, and
// returns a one-cycle ack. A sticky stall flag reports accesses stuck too long.
module sobel_mem_scheduler #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BUSY_LIMIT = 16
) (
  input  logic              i_clk,
  input  logic              i_n_rst,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_ack,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  input  logic              i_busy,
  input  logic              i_read_data_done,
  input  logic [DATA_W-1:0] i_data_r_o,
  input  logic              i_write_done,
  output logic              o_start_read,
  output logic              o_start_write,
  output logic [ADDR_W-1:0] o_addr_r_mc,
  output logic [ADDR_W-1:0] o_addr_w_mc,
  output logic [DATA_W-1:0] o_data_w,
  output logic              o_stall_err
);

  localparam int unsigned      CntW   = $clog2(BUSY_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(BUSY_LIMIT);

  typedef enum logic [2:0] {
    StIdle,
    StIssueRd,
    StIssueWr,
    StAckRd,
    StAckWr
  } state_e;

  state_e            r_state;
  logic              r_last_wr;  // 1: most recent grant went to the write side
  logic [CntW-1:0]   r_busy_cnt;
  logic              r_rd_ack;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_wr_ack;
  logic              r_start_read;
  logic              r_start_write;
  logic [ADDR_W-1:0] r_addr_r_mc;
  logic [ADDR_W-1:0] r_addr_w_mc;
  logic [DATA_W-1:0] r_data_w;
  logic              r_stall_err;

  logic              w_grant_rd;
  logic              w_grant_wr;
  logic              w_rd_cmp;
  logic              w_wr_cmp;
  logic [CntW-1:0]   w_cnt_next;

  // Round-robin: under contention the side that did not win last time is granted.
  assign w_grant_rd = i_rd_req & (~i_wr_req | r_last_wr);
  assign w_grant_wr = i_wr_req & (~i_rd_req | ~r_last_wr);

  // A completion reported while memory is still busy is not trusted.
  assign w_rd_cmp   = i_read_data_done & ~i_busy;
  assign w_wr_cmp   = i_write_done & ~i_busy;

  // Saturating busy counter increment.
  assign w_cnt_next = (r_busy_cnt == CntMax) ? r_busy_cnt : r_busy_cnt + CntW'(1);

  // Main FSM with registered Moore outputs; the address/data output registers
  // double as the request latches while in an ISSUE state.
  always_ff @(posedge i_clk) begin
    if (!i_n_rst) begin
      r_state       <= StIdle;
      r_last_wr     <= 1'b1;
      r_busy_cnt    <= '0;
      r_rd_ack      <= 1'b0;
      r_rd_data     <= '0;
      r_wr_ack      <= 1'b0;
      r_start_read  <= 1'b0;
      r_start_write <= 1'b0;
      r_addr_r_mc   <= '0;
      r_addr_w_mc   <= '0;
      r_data_w      <= '0;
      r_stall_err   <= 1'b0;
    end else begin
      r_rd_ack <= 1'b0;
      r_wr_ack <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_grant_rd) begin
            r_addr_r_mc  <= i_rd_addr;
            r_start_read <= 1'b1;
            r_last_wr    <= 1'b0;
            r_state      <= StIssueRd;
          end else if (w_grant_wr) begin
            r_addr_w_mc   <= i_wr_addr;
            r_data_w      <= i_wr_data;
            r_start_write <= 1'b1;
            r_last_wr     <= 1'b1;
            r_state       <= StIssueWr;
          end
        end
        StIssueRd: begin
          if (w_rd_cmp) begin
            r_rd_data    <= i_data_r_o;
            r_busy_cnt   <= '0;
            r_start_read <= 1'b0;
            r_addr_r_mc  <= '0;
            r_rd_ack     <= 1'b1;
            r_state      <= StAckRd;
          end else begin
            r_busy_cnt <= w_cnt_next;
            if (w_cnt_next == CntMax) r_stall_err <= 1'b1;
          end
        end
        StIssueWr: begin
          if (w_wr_cmp) begin
            r_busy_cnt    <= '0;
            r_start_write <= 1'b0;
            r_addr_w_mc   <= '0;
            r_data_w      <= '0;
            r_wr_ack      <= 1'b1;
            r_state       <= StAckWr;
          end else begin
            r_busy_cnt <= w_cnt_next;
            if (w_cnt_next == CntMax) r_stall_err <= 1'b1;
          end
        end
        StAckRd: r_state <= StIdle;
        StAckWr: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_rd_ack      = r_rd_ack;
  assign o_rd_data     = r_rd_data;
  assign o_wr_ack      = r_wr_ack;
  assign o_start_read  = r_start_read;
  assign o_start_write = r_start_write;
  assign o_addr_r_mc   = r_addr_r_mc;
  assign o_addr_w_mc   = r_addr_w_mc;
  assign o_data_w      = r_data_w;
  assign o_stall_err   = r_stall_err;

endmodule

// File: tb/tb_sobel_mem_scheduler.sv
// Directed self-checking bench for sobel_mem_scheduler.
// A tiny port-block model completes an access in the same cycle it is
// started unless busy is high.
module tb_sobel_mem_scheduler;

  logic       clk;
  logic       n_rst;
  logic       rd_req;
  logic [7:0] rd_addr;
  logic       rd_ack;
  logic [7:0] rd_data;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic       busy;
  logic       read_data_done;
  logic [7:0] data_r_o;
  logic       write_done;
  logic       start_read;
  logic       start_write;
  logic [7:0] addr_r_mc;
  logic [7:0] addr_w_mc;
  logic [7:0] data_w;
  logic       stall_err;

  logic [7:0] mem_ret;

  int n_pass  = 0;
  int n_total = 0;

  sobel_mem_scheduler #(
    .ADDR_W    (8),
    .DATA_W    (8),
    .BUSY_LIMIT(16)
  ) dut (
    .i_clk           (clk),
    .i_n_rst         (n_rst),
    .i_rd_req        (rd_req),
    .i_rd_addr       (rd_addr),
    .o_rd_ack        (rd_ack),
    .o_rd_data       (rd_data),
    .i_wr_req        (wr_req),
    .i_wr_addr       (wr_addr),
    .i_wr_data       (wr_data),
    .o_wr_ack        (wr_ack),
    .i_busy          (busy),
    .i_read_data_done(read_data_done),
    .i_data_r_o      (data_r_o),
    .i_write_done    (write_done),
    .o_start_read    (start_read),
    .o_start_write   (start_write),
    .o_addr_r_mc     (addr_r_mc),
    .o_addr_w_mc     (addr_w_mc),
    .o_data_w        (data_w),
    .o_stall_err     (stall_err)
  );

  // Port-block model: completion is combinational with the start command.
  assign read_data_done = start_read & ~busy;
  assign write_done     = start_write & ~busy;
  assign data_r_o       = mem_ret;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0; busy = 1'b0;
    rd_addr = 8'h00; wr_addr = 8'h00; wr_data = 8'h00; mem_ret = 8'h00;
    step();
    step();
    n_total++;
    if ({rd_ack, wr_ack, start_read, start_write, stall_err} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000",
               {rd_ack, wr_ack, start_read, start_write, stall_err});
    else n_pass++;
    n_total++;
    if ({rd_data, addr_r_mc, addr_w_mc, data_w} !== 32'h0)
      $display("FAIL reset_data: got %h want 00000000",
               {rd_data, addr_r_mc, addr_w_mc, data_w});
    else n_pass++;
    n_rst = 1'b1;
  endtask

  task automatic test_read();
    rd_req = 1'b1; rd_addr = 8'h12; mem_ret = 8'hA5;
    step();
    n_total++;
    if ({start_read, addr_r_mc} !== {1'b1, 8'h12})
      $display("FAIL read_issue: got start=%b addr=%h want 1 12", start_read, addr_r_mc);
    else n_pass++;
    n_total++;
    if ({rd_ack, start_write} !== 2'b00)
      $display("FAIL read_issue_quiet: got ack=%b sw=%b want 0 0", rd_ack, start_write);
    else n_pass++;
    rd_addr = 8'h99;  // change after grant must not matter
    step();
    n_total++;
    if ({rd_ack, rd_data} !== {1'b1, 8'hA5})
      $display("FAIL read_ack: got ack=%b data=%h want 1 a5", rd_ack, rd_data);
    else n_pass++;
    n_total++;
    if ({start_read, addr_r_mc} !== {1'b0, 8'h00})
      $display("FAIL read_ack_cmd: got start=%b addr=%h want 0 00", start_read, addr_r_mc);
    else n_pass++;
    rd_req = 1'b0;
    step();
    n_total++;
    if ({rd_ack, rd_data} !== {1'b0, 8'hA5})
      $display("FAIL read_hold: got ack=%b data=%h want 0 a5", rd_ack, rd_data);
    else n_pass++;
  endtask

  task automatic test_write();
    wr_req = 1'b1; wr_addr = 8'h40; wr_data = 8'h7F;
    step();
    n_total++;
    if ({start_write, addr_w_mc, data_w} !== {1'b1, 8'h40, 8'h7F})
      $display("FAIL write_issue: got start=%b addr=%h data=%h want 1 40 7f",
               start_write, addr_w_mc, data_w);
    else n_pass++;
    n_total++;
    if ({start_read, wr_ack} !== 2'b00)
      $display("FAIL write_issue_quiet: got sr=%b ack=%b want 0 0", start_read, wr_ack);
    else n_pass++;
    wr_addr = 8'hEE; wr_data = 8'h11;
    step();
    n_total++;
    if ({wr_ack, start_write} !== 2'b10)
      $display("FAIL write_ack: got ack=%b start=%b want 1 0", wr_ack, start_write);
    else n_pass++;
    wr_req = 1'b0;
    step();
    n_total++;
    if (wr_ack !== 1'b0)
      $display("FAIL write_ack_pulse: got %b want 0", wr_ack);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] order;  // bit i: 1 = write granted on grant i
    logic [3:0] exp_order;
    int grants;
    int clashes;
    exp_order = 4'b1010;  // grant0 READ, grant1 WRITE, grant2 READ, grant3 WRITE
    order = 4'b0; grants = 0; clashes = 0;
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    rd_req = 1'b1; wr_req = 1'b1;
    rd_addr = 8'h21; wr_addr = 8'h31; wr_data = 8'h41; mem_ret = 8'h5A;
    for (int k = 0; k < 40 && grants < 4; k++) begin
      step();
      if (start_read && start_write) clashes++;
      if (start_read || start_write) begin
        order[grants] = start_write;
        grants++;
      end
    end
    rd_req = 1'b0; wr_req = 1'b0;
    step();
    step();
    n_total++;
    if (grants !== 4)
      $display("FAIL rr_grant_count: got %0d want 4", grants);
    else n_pass++;
    for (int g = 0; g < 4; g++) begin
      n_total++;
      if (order[g] !== exp_order[g])
        $display("FAIL rr_order_%0d: got %s want %s", g,
                 order[g] ? "WRITE" : "READ", exp_order[g] ? "WRITE" : "READ");
      else n_pass++;
    end
    n_total++;
    if (clashes !== 0)
      $display("FAIL rr_exclusive: got %0d clashes want 0", clashes);
    else n_pass++;
  endtask

  task automatic test_busy_read();
    int hi;
    int ack_k;
    hi = 0; ack_k = -1;
    busy = 1'b1; rd_req = 1'b1; rd_addr = 8'h33; mem_ret = 8'h5C;
    for (int k = 0; k < 30; k++) begin
      step();
      if (start_read) hi++;
      if (rd_ack) begin
        ack_k = k;
        break;
      end
      if (hi == 6) busy = 1'b0;  // five busy ISSUE cycles, sixth completes
    end
    rd_req = 1'b0;
    n_total++;
    if (hi !== 6)
      $display("FAIL busy_rd_start_len: got %0d want 6", hi);
    else n_pass++;
    n_total++;
    if (ack_k !== 6)
      $display("FAIL busy_rd_ack_cycle: got %0d want 6", ack_k);
    else n_pass++;
    n_total++;
    if ({rd_data, stall_err} !== {8'h5C, 1'b0})
      $display("FAIL busy_rd_data: got data=%h stall=%b want 5c 0", rd_data, stall_err);
    else n_pass++;
    busy = 1'b0;
    step();
    n_total++;
    if (rd_ack !== 1'b0)
      $display("FAIL busy_rd_ack_pulse: got %b want 0", rd_ack);
    else n_pass++;
  endtask

  task automatic test_stall();
    busy = 1'b1; wr_req = 1'b1; wr_addr = 8'h50; wr_data = 8'h60;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 16) begin
        n_total++;
        if (stall_err !== 1'b0)
          $display("FAIL stall_early: got %b want 0 after 15 busy cycles", stall_err);
        else n_pass++;
      end
      if (i == 17) begin
        n_total++;
        if (stall_err !== 1'b1)
          $display("FAIL stall_set: got %b want 1 after 16 busy cycles", stall_err);
        else n_pass++;
      end
      if (i == 20) begin
        n_total++;
        if ({start_write, addr_w_mc} !== {1'b1, 8'h50})
          $display("FAIL stall_no_abort: got start=%b addr=%h want 1 50",
                   start_write, addr_w_mc);
        else n_pass++;
      end
    end
    busy = 1'b0;
    step();
    n_total++;
    if ({wr_ack, stall_err} !== 2'b11)
      $display("FAIL stall_ack: got ack=%b stall=%b want 1 1", wr_ack, stall_err);
    else n_pass++;
    wr_req = 1'b0;
    step();
    step();
    n_total++;
    if (stall_err !== 1'b1)
      $display("FAIL stall_sticky: got %b want 1", stall_err);
    else n_pass++;
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    n_total++;
    if (stall_err !== 1'b0)
      $display("FAIL stall_clear: got %b want 0", stall_err);
    else n_pass++;
  endtask

  task automatic test_reset_inflight();
    int acks;
    acks = 0;
    busy = 1'b1; rd_req = 1'b1; rd_addr = 8'h77; mem_ret = 8'hC3;
    step();
    n_total++;
    if (start_read !== 1'b1)
      $display("FAIL inflight_issue: got %b want 1", start_read);
    else n_pass++;
    rd_req = 1'b0; n_rst = 1'b0;
    step();
    n_total++;
    if ({rd_ack, wr_ack, start_read, start_write, stall_err, rd_data, addr_r_mc,
         addr_w_mc, data_w} !== 37'h0)
      $display("FAIL inflight_reset_outs: got %h want 0",
               {rd_ack, wr_ack, start_read, start_write, stall_err, rd_data,
                addr_r_mc, addr_w_mc, data_w});
    else n_pass++;
    n_rst = 1'b1; busy = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (rd_ack) acks++;
    end
    n_total++;
    if (acks !== 0)
      $display("FAIL inflight_no_ack: got %0d acks want 0", acks);
    else n_pass++;
    n_total++;
    if (start_read !== 1'b0)
      $display("FAIL inflight_idle: got start_read=%b want 0", start_read);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_busy_read();
    test_stall();
    test_reset_inflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/sobel_mem_scheduler.md
Name: sobel_mem_scheduler

Overview:
- Sequences the pixel memory read/write port block on behalf of two requesters: the 3x3 window fetch unit (reads) and the gradient writeback unit (writes).
- Arbitrates round-robin, latches each request, and drives the start_read/start_write, address and data inputs of the port block.
- Waits out memory busy, returns read data with a one-cycle ack, and flags a sticky stall error when busy persists.

Parameters:
- ADDR_W, 8, address width; must match the port block.
- DATA_W, 8, pixel data width.
- BUSY_LIMIT, 16, consecutive ISSUE cycles without completion before stall_err sets.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- n_rst  in  1  synchronous active-low reset.
- rd_req  in  1  fetch unit requests a read.
- rd_addr  in  ADDR_W  read address; sampled only when the request is granted.
- rd_ack  out  1  one-cycle pulse; rd_data valid.
- rd_data  out  DATA_W  last read pixel; held until the next read ack.
- wr_req  in  1  writeback unit requests a write.
- wr_addr  in  ADDR_W  write address; sampled on grant.
- wr_data  in  DATA_W  write data; sampled on grant.
- wr_ack  out  1  one-cycle pulse; write committed.
- busy  in  1  memory busy.
- read_data_done  in  1  port block read completion (combinational with start_read).
- data_r_o  in  DATA_W  read data from the port block; valid when read_data_done=1.
- write_done  in  1  port block write completion.
- start_read  out  1  read command to the port block.
- start_write  out  1  write command to the port block.
- addr_r_mc  out  ADDR_W  read address to the port block.
- addr_w_mc  out  ADDR_W  write address to the port block.
- data_w  out  DATA_W  write data to the port block.
- stall_err  out  1  sticky busy-timeout flag.

Behaviour:
- Reset (n_rst=0 at clk edge):
  - State goes to IDLE.
  - All outputs go to 0, including rd_data and stall_err.
  - last_grant is set to WRITE, so the first contended grant goes to read.
  - Busy counter clears.
  - An in-flight access is dropped with no ack.
- States: IDLE, ISSUE_RD, ISSUE_WR, ACK_RD, ACK_WR.
- IDLE:
  - Only rd_req=1: latch rd_addr and go to ISSUE_RD.
  - Only wr_req=1: latch wr_addr and wr_data and go to ISSUE_WR.
  - Both high: grant the side opposite last_grant, then update last_grant.
  - Neither high: stay in IDLE.
- ISSUE_RD:
  - start_read=1 and addr_r_mc=latched address. Both are Moore outputs, 0 in every other state.
  - read_data_done=1: capture data_r_o into rd_data, clear the busy counter, go to ACK_RD.
  - Otherwise stay in ISSUE_RD and increment the busy counter.
- ISSUE_WR:
  - start_write=1, addr_w_mc=latched address, data_w=latched data.
  - write_done=1: clear the busy counter and go to ACK_WR.
  - Otherwise stay in ISSUE_WR and increment the busy counter.
- Ack states:
  - ACK_RD: rd_ack=1 for one cycle, then IDLE.
  - ACK_WR: wr_ack=1 for one cycle, then IDLE.
- Latency: request seen in IDLE at cycle t, no busy → issue at t+1, ack at t+2. Peak throughput is one access per 3 cycles.
- Requester rule: drop req in the ack cycle. A req still high when the FSM is back in IDLE is a new request.
- Busy timeout:
  - The counter saturates at BUSY_LIMIT.
  - When it reaches BUSY_LIMIT, stall_err sets and stays set until reset.
  - The access is not aborted; the FSM keeps waiting.
- Requests arriving during ISSUE or ACK are ignored until IDLE. Input changes after grant do not affect the latched address or data.
- Reads and writes are never issued in the same cycle; start_read and start_write are mutually exclusive.

Test Plan:
- Reset, then rd_req=1 with rd_addr=0x12, busy=0, port returns 0xA5 → start_read=1 and addr_r_mc=0x12 at cycle 1; rd_ack=1 and rd_data=0xA5 at cycle 2.
- wr_req=1 with wr_addr=0x40 and wr_data=0x7F → start_write=1, addr_w_mc=0x40, data_w=0x7F for one cycle; wr_ack pulses the next cycle.
- rd_req and wr_req held high for 4 grants after reset → grant order READ, WRITE, READ, WRITE; start_read and start_write never both high.
- Read issued with busy=1 for 5 cycles, then busy=0 → start_read held 6 cycles, rd_ack one cycle later, stall_err stays 0.
- busy=1 held for 20 cycles during ISSUE_WR → stall_err=1 after 16 cycles and stays 1 after busy drops and wr_ack fires; clears only on n_rst=0.
- n_rst=0 asserted during ISSUE_RD → next cycle all outputs are 0 and state is IDLE; no rd_ack is ever produced for the dropped access.
